// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the multi-channel push-button/switch debouncer:
//   - db_state_e : per-channel Moore FSM state (2-bit encoding)
//   - CLK_HZ, DEBOUNCE_MS : default board timing
//   - DEFAULT_FINAL_VALUE : stability window in clk cycles derived from them
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_e;

    localparam int unsigned CLK_HZ              = 100_000_000;
    localparam int unsigned DEBOUNCE_MS         = 20;
    localparam int unsigned DEFAULT_FINAL_VALUE = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: SYNC_STAGES-deep synchroniser, stability counter,
// 4-state Moore FSM and registered edge strobes.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   noisy_in     in   raw asynchronous input bit
//   debounce_out out  registered debounced level
//   rise_pulse   out  one-cycle strobe, first cycle debounce_out is 1
//   fall_pulse   out  one-cycle strobe, first cycle debounce_out is 0
//   change_d     out  next-cycle value of (rise_pulse | fall_pulse), used by
//                     the parent to register a bank-wide change strobe
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned FINAL_VALUE = DEFAULT_FINAL_VALUE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy_in,
    output logic debounce_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_d
);

    localparam int unsigned      CNT_W   = $clog2(FINAL_VALUE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FINAL_VALUE);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], noisy_in};
    end

    // A reversion of the synchronised input before terminal count always wins
    // over the count check, so a glitch restarts the window from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LO: begin
                if (sync_bit) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_bit) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!sync_bit) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (sync_bit) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase

        // Output decoded from the next state so the registered level moves on
        // the same edge as the state register.
        out_d  = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign debounce_out = out_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign change_d     = rise_d | fall_d;

endmodule

// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
// Bank of CHANNELS independent debouncers between raw board inputs and user
// logic. All outputs are registered in the clk domain.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   noisy_in     in   [CHANNELS] raw asynchronous inputs
//   debounce_out out  [CHANNELS] debounced levels
//   rise_pulse   out  [CHANNELS] one-cycle 0->1 strobes
//   fall_pulse   out  [CHANNELS] one-cycle 1->0 strobes
//   any_change   out  registered OR of all strobes, aligned with them
// -----------------------------------------------------------------------------
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned FINAL_VALUE = DEFAULT_FINAL_VALUE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] debounce_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    logic [CHANNELS-1:0] change_d;
    logic                any_change_q, any_change_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .FINAL_VALUE (FINAL_VALUE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .noisy_in     (noisy_in[i]),
            .debounce_out (debounce_out[i]),
            .rise_pulse   (rise_pulse[i]),
            .fall_pulse   (fall_pulse[i]),
            .change_d     (change_d[i])
        );
    end

    // Built from the channels' next-cycle strobes so the registered OR lands
    // in the same cycle as the per-channel pulses.
    always_comb begin
        any_change_d = |change_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
// Directed bench for debouncer_multi (CHANNELS=4, FINAL_VALUE=3,
// SYNC_STAGES=2). A run-length model predicts every output each cycle: the
// level flips once the synchronised input has disagreed with it on
// FINAL_VALUE+2 consecutive edges. Literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

    localparam int CH = 4;
    localparam int FV = 3;
    localparam int SS = 2;

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] noisy_in;
    logic [CH-1:0] debounce_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic          any_change;

    debouncer_multi #(
        .CHANNELS    (CH),
        .FINAL_VALUE (FV),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .noisy_in     (noisy_in),
        .debounce_out (debounce_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .any_change   (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // model state
    logic [SS-1:0] m_hist [CH];
    int            m_run  [CH];
    logic [CH-1:0] m_out, m_rise, m_fall;
    logic          m_any;

    int rise_cnt [CH];
    int fall_cnt [CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_hist[c] = '0;
            m_run[c]  = 0;
        end
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_any  = 1'b0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] r, f;
        r = '0;
        f = '0;
        for (int c = 0; c < CH; c++) begin
            logic s;
            s = m_hist[c][SS-1];
            m_hist[c] = {m_hist[c][SS-2:0], noisy_in[c]};
            if (s != m_out[c]) begin
                m_run[c]++;
                if (m_run[c] == FV + 2) begin
                    m_out[c] = s;
                    r[c]     = s;
                    f[c]     = ~s;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_rise = r;
        m_fall = f;
        m_any  = |(r | f);
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end
    endtask

    // One clock: advance the model on the edge, then compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_clear();
        else model_edge();
        #1;
        chk("debounce_out", 32'(debounce_out), 32'(m_out));
        chk("rise_pulse",   32'(rise_pulse),   32'(m_rise));
        chk("fall_pulse",   32'(fall_pulse),   32'(m_fall));
        chk("any_change",   32'(any_change),   32'(m_any));
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] += int'(rise_pulse[c]);
            fall_cnt[c] += int'(fall_pulse[c]);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int widths [6];
        widths = '{1, 1, 2, 2, 3, 3};
        model_clear();
        clear_counts();

        // 1. Reset with all inputs high; edge 0 is the first edge after release.
        reset_n  = 1'b0;
        noisy_in = 4'hF;
        ticks(2);
        chk("reset_out", 32'(debounce_out), 32'h0);
        chk("reset_any", 32'(any_change), 32'h0);
        reset_n = 1'b1;
        ticks(6);                                   // edges 0..5
        chk("t1_edge5_out", 32'(debounce_out), 32'h0);
        tick();                                     // edge 6
        chk("t1_edge6_out",  32'(debounce_out), 32'hF);
        chk("t1_edge6_rise", 32'(rise_pulse), 32'hF);
        chk("t1_edge6_any",  32'(any_change), 32'h1);
        tick();
        chk("t1_rise_gone", 32'(rise_pulse), 32'h0);
        chk("t1_any_gone",  32'(any_change), 32'h0);
        noisy_in = 4'h0;
        ticks(10);
        chk("t1_all_low", 32'(debounce_out), 32'h0);

        // 2. Clean step on channel 0.
        clear_counts();
        noisy_in[0] = 1'b1;
        ticks(6);                                   // edges k..k+5
        chk("t2_k5_out", 32'(debounce_out), 32'h0);
        tick();                                     // edge k+6
        chk("t2_k6_out",  32'(debounce_out), 32'h1);
        chk("t2_k6_rise", 32'(rise_pulse), 32'h1);
        ticks(4);
        chk("t2_one_rise", 32'(rise_cnt[0]), 32'd1);

        // 3. Bounce on channel 1 with 2-cycle half-periods.
        clear_counts();
        for (int c = 0; c < 20; c++) begin
            noisy_in[1] = ((c / 2) % 2) == 0;
            tick();
        end
        noisy_in[1] = 1'b0;
        ticks(8);
        chk("t3_out1",    32'(debounce_out[1]), 32'h0);
        chk("t3_pulses1", 32'(rise_cnt[1] + fall_cnt[1]), 32'd0);

        // 4. Bounce at 1/2/3-cycle widths, then settle high on channel 2.
        clear_counts();
        for (int w = 0; w < 6; w++) begin
            noisy_in[2] = (w % 2) == 0;
            ticks(widths[w]);
        end
        noisy_in[2] = 1'b1;
        ticks(6);
        chk("t4_k5_out2", 32'(debounce_out[2]), 32'h0);
        tick();
        chk("t4_k6_out2",  32'(debounce_out[2]), 32'h1);
        chk("t4_k6_rise2", 32'(rise_pulse[2]), 32'h1);
        ticks(4);
        chk("t4_one_rise2", 32'(rise_cnt[2]), 32'd1);

        // 5. Channel 0 falls while channel 3 rises on the same edge.
        clear_counts();
        noisy_in[0] = 1'b0;
        noisy_in[3] = 1'b1;
        ticks(7);
        chk("t5_fall", 32'(fall_pulse), 32'h1);
        chk("t5_rise", 32'(rise_pulse), 32'h8);
        chk("t5_any",  32'(any_change), 32'h1);
        chk("t5_out",  32'(debounce_out), 32'hC);
        tick();
        chk("t5_any_gone", 32'(any_change), 32'h0);

        // 6. Asynchronous reset while ch0 is high and ch1 is mid-count.
        noisy_in[0] = 1'b1;
        ticks(8);
        chk("t6_pre_out", 32'(debounce_out), 32'hD);
        noisy_in[1] = 1'b1;
        ticks(4);
        #2;
        reset_n  = 1'b0;
        noisy_in = 4'h0;
        model_clear();
        #1;
        chk("t6_async_out",  32'(debounce_out), 32'h0);
        chk("t6_async_rise", 32'(rise_pulse), 32'h0);
        chk("t6_async_fall", 32'(fall_pulse), 32'h0);
        chk("t6_async_any",  32'(any_change), 32'h0);
        clear_counts();
        ticks(2);
        reset_n = 1'b1;
        ticks(12);
        chk("t6_no_fall0",  32'(fall_cnt[0]), 32'd0);
        chk("t6_quiet_out", 32'(debounce_out), 32'h0);
        chk("t6_no_rise1",  32'(rise_cnt[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
